// File: rtl/reg_slice_pkg.sv
// Shared types and helpers for the reg_slice pipeline register.
// Stage occupancy states and the capacity calculation used for port sizing.
package reg_slice_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

   function automatic int slice_cap(input int stages, input int full_skid);
      return stages * ((full_skid != 0) ? 2 : 1);
   endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// One register-slice stage: main register plus optional skid register.
// in_ready comes from a flop (gated only by flush), never from out_ready.
module reg_slice_stage
   import reg_slice_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               FULL_SKID   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam bit SKID = (FULL_SKID != 0);

   stage_state_t     state_q, state_d;
   logic             rdy_q, rdy_d;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             in_fire, out_fire;
   logic             load_main_in, load_main_skid, load_skid;

   // Handshake: a beat moves on a rising edge only when valid and ready are both 1.
   assign in_ready  = rdy_q & ~flush;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (in_fire) state_d = ST_ONE;
         ST_ONE: begin
            if (in_fire && !out_fire) begin
               if (SKID) state_d = ST_TWO;
            end else if (!in_fire && out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO:   if (out_fire) state_d = ST_ONE;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
   end

   always_comb begin
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         ST_EMPTY: load_main_in = in_fire;
         ST_ONE: begin
            load_main_in = in_fire & out_fire;
            load_skid    = SKID & in_fire & ~out_fire;
         end
         ST_TWO:   load_main_skid = out_fire;
         default: ;
      endcase
      // Ready for the next cycle is decided from the state we are about to enter.
      rdy_d = SKID ? (state_d != ST_TWO) : (state_d == ST_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= RESET_VALUE;
         skid_q <= RESET_VALUE;
      end else if (flush) begin
         main_q <= RESET_VALUE;
         skid_q <= RESET_VALUE;
      end else begin
         if (load_main_in)        main_q <= in_data;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

endmodule

// File: rtl/reg_slice.sv
// Chain of STAGES register-slice stages with an entry counter.
// Stages connect point-to-point, so no ready path crosses a stage boundary.
module reg_slice
   import reg_slice_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               STAGES      = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               FULL_SKID   = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 flush,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   input  logic [WIDTH-1:0]                                     in_data,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   output logic [WIDTH-1:0]                                     out_data,
   output logic [$clog2(slice_cap(STAGES, FULL_SKID)+1)-1:0]    occupancy
);

   localparam int OCC_W = $clog2(slice_cap(STAGES, FULL_SKID) + 1);

   logic             link_valid [STAGES+1];
   logic             link_ready [STAGES+1];
   logic [WIDTH-1:0] link_data  [STAGES+1];
   logic [OCC_W-1:0] occ_q;
   logic             accept, deliver;

   assign link_valid[0]      = in_valid;
   assign link_data[0]       = in_data;
   assign in_ready           = link_ready[0];
   assign out_valid          = link_valid[STAGES];
   assign out_data           = link_data[STAGES];
   assign link_ready[STAGES] = out_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      reg_slice_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE),
         .FULL_SKID   (FULL_SKID)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (link_valid[i]),
         .in_ready  (link_ready[i]),
         .in_data   (link_data[i]),
         .out_valid (link_valid[i+1]),
         .out_ready (link_ready[i+1]),
         .out_data  (link_data[i+1])
      );
   end

   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   // Simultaneous accept and deliver cancel; flush wins over both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else if (accept && !deliver) begin
         occ_q <= occ_q + OCC_W'(1);
      end else if (!accept && deliver) begin
         occ_q <= occ_q - OCC_W'(1);
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_slice.sv
// Bench for reg_slice: three configurations driven side by side, each
// checked against a queue model of an order-preserving bounded buffer.
module tb_reg_slice;

   localparam int             W  = 16;
   localparam int             N  = 3;
   localparam logic [W-1:0]   RV = 16'hC3C3;
   localparam int             CAP [N]    = '{2, 4, 1};
   localparam bit             SINGLE [N] = '{1'b1, 1'b0, 1'b1};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [N];
   logic         out_ready [N];
   logic         flush     [N];
   logic [W-1:0] in_data   [N];
   logic         in_ready  [N];
   logic         out_valid [N];
   logic [W-1:0] out_data  [N];
   logic [1:0]   occ_a;
   logic [2:0]   occ_b;
   logic [0:0]   occ_c;
   logic [31:0]  occ [N];

   logic [W-1:0] exp_q [N][$];
   int           checks, failures;
   int           acc_cnt [N];
   int           del_cnt [N];
   bit           stall [N];
   logic [W-1:0] held  [N];

   assign occ[0] = {30'd0, occ_a};
   assign occ[1] = {29'd0, occ_b};
   assign occ[2] = {31'd0, occ_c};

   always #5 clk = ~clk;

   reg_slice #(.WIDTH(W), .STAGES(1), .RESET_VALUE(RV), .FULL_SKID(1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .occupancy(occ_a));

   reg_slice #(.WIDTH(W), .STAGES(2), .RESET_VALUE(RV), .FULL_SKID(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .occupancy(occ_b));

   reg_slice #(.WIDTH(W), .STAGES(1), .RESET_VALUE(RV), .FULL_SKID(0)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(flush[2]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .occupancy(occ_c));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      for (int k = 0; k < N; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         flush[k]     = 1'b0;
         in_data[k]   = '0;
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < N; k++) begin
         exp_q[k].delete();
         stall[k] = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < N; k++) begin
         check_eq({tag, "_in_ready"},  in_ready[k],  1'b0);
         check_eq({tag, "_out_valid"}, out_valid[k], 1'b0);
         check_eq({tag, "_occ"},       occ[k],       0);
         check_eq({tag, "_out_data"},  out_data[k],  RV);
      end
   endtask

   // Called just after a falling edge with this cycle's inputs already driven.
   task automatic cycle();
      bit fi, fo;
      #1;
      for (int k = 0; k < N; k++) begin
         if (SINGLE[k]) begin
            check_eq("in_ready", in_ready[k], !flush[k] && (exp_q[k].size() < CAP[k]));
            check_eq("out_valid", out_valid[k], exp_q[k].size() > 0);
         end else begin
            if (exp_q[k].size() == CAP[k]) check_eq("full_blocks_in", in_ready[k], 1'b0);
            if (exp_q[k].size() == 0)      check_eq("empty_no_valid", out_valid[k], 1'b0);
         end
         if (flush[k]) check_eq("flush_in_ready", in_ready[k], 1'b0);
         fi = in_valid[k] && in_ready[k];
         fo = out_valid[k] && out_ready[k];
         stall[k] = out_valid[k] && !out_ready[k] && !flush[k];
         held[k]  = out_data[k];
         if (flush[k]) begin
            exp_q[k].delete();
         end else begin
            if (fo) begin
               if (exp_q[k].size() == 0) check_eq("underflow", out_valid[k], 1'b0);
               else begin
                  check_eq("order", out_data[k], exp_q[k].pop_front());
                  del_cnt[k]++;
               end
            end
            if (fi) begin
               exp_q[k].push_back(in_data[k]);
               acc_cnt[k]++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         check_eq("occupancy", occ[k], exp_q[k].size());
         if (stall[k]) begin
            check_eq("hold_valid", out_valid[k], 1'b1);
            check_eq("hold_data", out_data[k], held[k]);
         end
      end
   endtask

   initial begin
      int a0, d0, total, guard;
      checks = 0;
      failures = 0;
      for (int k = 0; k < N; k++) begin
         acc_cnt[k] = 0;
         del_cnt[k] = 0;
      end
      clear_model();
      set_idle();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_eq("pre_edge_in_ready", in_ready[0], 1'b0);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) check_eq("post_reset_in_ready", in_ready[k], 1'b1);

      // Back-to-back pushes through a single full-rate stage.
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = 16'h0011;
      cycle();
      check_eq("lat1_valid", out_valid[0], 1'b1);
      check_eq("lat1_data",  out_data[0],  16'h0011);
      in_data[0] = 16'h0022;
      cycle();
      check_eq("b2b_data2", out_data[0], 16'h0022);
      in_data[0] = 16'h0033;
      cycle();
      check_eq("b2b_data3", out_data[0], 16'h0033);
      in_valid[0] = 1'b0;
      cycle();
      check_eq("b2b_drained", out_valid[0], 1'b0);

      // Fill the two-stage slice with the output stalled.
      a0 = acc_cnt[1];
      guard = 0;
      while (in_ready[1] && guard < 12) begin
         in_valid[1] = 1'b1;
         in_data[1]  = 16'h0100 + 16'(guard);
         cycle();
         guard++;
      end
      in_valid[1] = 1'b0;
      check_eq("fill_count", acc_cnt[1] - a0, 4);
      check_eq("fill_occ",   occ[1], 4);
      d0 = del_cnt[1];
      out_ready[1] = 1'b1;
      guard = 0;
      while (exp_q[1].size() > 0 && guard < 12) begin
         cycle();
         guard++;
      end
      check_eq("drain_count", del_cnt[1] - d0, 4);
      check_eq("drain_occ",   occ[1], 0);
      out_ready[1] = 1'b0;

      // Half-rate stage under continuous traffic.
      a0 = acc_cnt[2];
      in_valid[2]  = 1'b1;
      out_ready[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data[2] = 16'h0200 + 16'(i);
         cycle();
         check_eq("half_occ", occ[2], (i % 2 == 0) ? 1 : 0);
      end
      check_eq("half_rate_count", acc_cnt[2] - a0, 4);
      in_valid[2]  = 1'b0;
      out_ready[2] = 1'b0;

      // Flush against a held entry with a new beat offered.
      in_valid[0]  = 1'b1;
      in_data[0]   = 16'h00A5;
      out_ready[0] = 1'b0;
      cycle();
      check_eq("flush_pre_data", out_data[0], 16'h00A5);
      in_data[0] = 16'h0077;
      flush[0]   = 1'b1;
      #1 check_eq("flush_blocks", in_ready[0], 1'b0);
      cycle();
      check_eq("flush_valid", out_valid[0], 1'b0);
      check_eq("flush_occ",   occ[0], 0);
      check_eq("flush_data",  out_data[0], RV);
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      cycle();

      // Asynchronous reset dropped between edges with entries held.
      in_valid[0] = 1'b1; in_data[0] = 16'h0E01;
      in_valid[1] = 1'b1; in_data[1] = 16'h0E02;
      cycle();
      cycle();
      set_idle();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      clear_model();
      @(posedge clk);
      @(negedge clk);
      check_eq("reset_held_ready", in_ready[1], 1'b0);
      rst_n = 1'b1;
      #1 check_eq("release_pre_edge", in_ready[1], 1'b0);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) check_eq("release_ready", in_ready[k], 1'b1);
      for (int k = 0; k < N; k++) out_ready[k] = 1'b1;
      repeat (3) cycle();
      check_eq("no_stale", out_valid[1], 1'b0);

      // Random valid/ready/flush traffic on all three slices.
      total = 0;
      guard = 0;
      while (total < 10000 && guard < 40000) begin
         for (int k = 0; k < N; k++) begin
            in_valid[k]  = ($urandom_range(0, 99) < 70);
            out_ready[k] = ($urandom_range(0, 99) < 60);
            flush[k]     = ($urandom_range(0, 299) == 0);
            in_data[k]   = W'($urandom);
         end
         cycle();
         total = del_cnt[0] + del_cnt[1] + del_cnt[2];
         guard++;
      end
      check_eq("random_transfers", total >= 10000, 1'b1);
      set_idle();
      for (int k = 0; k < N; k++) out_ready[k] = 1'b1;
      repeat (10) cycle();
      for (int k = 0; k < N; k++) check_eq("final_empty", occ[k], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
